// File: rtl/xvga_timing_gen.sv
// Parametrised raster timing generator: registered coordinates, sync, blank and strobes,
// plus a DELAY-stage aligned copy. Optional frame counter guarded by XVGA_FRAME_COUNT_EN.
module xvga_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int X_W       = 11,
  parameter int Y_W       = 10,
  parameter int DELAY     = 1,
  parameter int FRAME_W   = 16
) (
  input  logic               vclock,
  input  logic               reset_n,
  input  logic               en,
  output logic [X_W-1:0]     displayx,
  output logic [Y_W-1:0]     displayy,
  output logic               hsync,
  output logic               vsync,
  output logic               blank,
  output logic               line_start,
  output logic               frame_start,
  output logic [X_W-1:0]     displayx_d,
  output logic [Y_W-1:0]     displayy_d,
  output logic               hsync_d,
  output logic               vsync_d,
  output logic               blank_d,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2**X_W) begin : g_bad_xw
    $error("xvga_timing_gen: H_TOTAL does not fit in X_W bits");
  end
  if (V_TOTAL > 2**Y_W) begin : g_bad_yw
    $error("xvga_timing_gen: V_TOTAL does not fit in Y_W bits");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_porch
    $error("xvga_timing_gen: porch and sync widths must be non-zero");
  end

  localparam logic [X_W-1:0] H_LAST    = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0] V_LAST    = Y_W'(V_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT     = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0] V_ACT     = Y_W'(V_ACTIVE);
  localparam logic [X_W-1:0] H_SYNC_S  = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] H_SYNC_E  = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_SYNC_S  = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] V_SYNC_E  = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           hs_q, hs_d, vs_q, vs_d, bl_q, bl_d, ls_q, ls_d, fs_q, fs_d;
  logic           line_wrap, frame_wrap;

  // Sync/blank/strobes are derived from the next coordinates so they land in the
  // same register update as the coordinates they describe.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    x_d        = x_q;
    y_d        = y_q;
    line_wrap  = (x_q == H_LAST);
    frame_wrap = line_wrap && (y_q == V_LAST);
    if (en) begin
      if (line_wrap) begin
        x_d = '0;
        y_d = frame_wrap ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    hs_d = ((x_d >= H_SYNC_S) && (x_d < H_SYNC_E)) ? HSYNC_POL : ~HSYNC_POL;
    vs_d = ((y_d >= V_SYNC_S) && (y_d < V_SYNC_E)) ? VSYNC_POL : ~VSYNC_POL;
    bl_d = (x_d >= H_ACT) || (y_d >= V_ACT);
    ls_d = (x_d == '0);
    fs_d = (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) begin
      x_q  <= '0;
      y_q  <= '0;
      hs_q <= ~HSYNC_POL;
      vs_q <= ~VSYNC_POL;
      bl_q <= 1'b0;
      ls_q <= 1'b1;
      fs_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      x_q  <= x_d;
      y_q  <= y_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      bl_q <= bl_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end
  end

  assign displayx    = x_q;
  assign displayy    = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign blank       = bl_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

  localparam int P_W = X_W + Y_W + 3;
  localparam logic [P_W-1:0] P_RST = {X_W'(0), Y_W'(0), ~HSYNC_POL, ~VSYNC_POL, 1'b0};

  logic [P_W-1:0] s0, s_out;
  assign s0 = {x_q, y_q, hs_q, vs_q, bl_q};

  if (DELAY == 0) begin : g_nodelay
    assign s_out = s0;
  end else begin : g_delay
    logic [P_W-1:0] pipe_q [DELAY];
    logic [P_W-1:0] pipe_d [DELAY];

    always_comb begin
      pipe_d = pipe_q;
      if (en) begin
        pipe_d[0] = s0;
        for (int i = 1; i < DELAY; i++) pipe_d[i] = pipe_q[i-1];
      end
    end

    // NOTE: this shift register is reset (unlike a RAM) so the delayed group starts coherent with stage 0.
    always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DELAY; i++) pipe_q[i] <= P_RST;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign s_out = pipe_q[DELAY-1];
  end

  assign {displayx_d, displayy_d, hsync_d, vsync_d, blank_d} = s_out;

`ifdef XVGA_FRAME_COUNT_EN
  logic [FRAME_W-1:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (en && frame_wrap) fc_d = fc_q + 1'b1;
  end

  always_ff @(posedge vclock or negedge reset_n) begin
    if (!reset_n) fc_q <= '0;
    else          fc_q <= fc_d;
  end

  assign frame_count = fc_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: doc/xvga_timing_gen.md
Name: xvga_timing_gen

Overview:
Parametrised successor to the fixed 1024x768 XVGA generator. Produces pixel coordinates, sync and blank for any raster, sized by parameters. Adds a clock enable, sync polarity control, line/frame start strobes, and a built-in DELAY-stage aligned pipeline so sprite logic with deeper latency taps one instance. Sits at the head of the video path and feeds sprites and the pixel mux.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, hsync width (pixels)
H_BP, 160, horizontal back porch (pixels)
V_ACTIVE, 768, visible lines
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vsync width (lines)
V_BP, 29, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync (0 = active-low)
X_W, 11, width of x coordinate
Y_W, 10, width of y coordinate
DELAY, 1, pipeline stages on the delayed output group (0 allowed)
FRAME_W, 16, frame counter width

Ports:
vclock  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
en  in  1  advance enable; low freezes counters and pipeline
displayx  out  X_W  current pixel x, stage 0
displayy  out  Y_W  current line y, stage 0
hsync  out  1  stage-0 hsync
vsync  out  1  stage-0 vsync
blank  out  1  stage-0 blank, high outside the active area
line_start  out  1  stage-0 strobe, high while displayx == 0
frame_start  out  1  stage-0 strobe, high while displayx == 0 and displayy == 0
displayx_d  out  X_W  displayx delayed DELAY enabled cycles
displayy_d  out  Y_W  displayy delayed
hsync_d, vsync_d, blank_d  out  1 each  delayed sync/blank
frame_count  out  FRAME_W  completed-frame count (see Optional Feature)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1344). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 806).
- Elaboration fails ($error) if H_TOTAL > 2**X_W, V_TOTAL > 2**Y_W, or any porch/sync parameter is 0.
- Reset (reset_n low, asynchronous): displayx=0, displayy=0, blank=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, line_start=1, frame_start=1. Every delayed stage loads the same values. frame_count=0.
- All stage-0 outputs are registers. Sync, blank and strobes are computed from the next coordinate values, so on every cycle they describe exactly the pixel at (displayx, displayy). No skew between the outputs.
- Each vclock with en=1:
  - displayx increments.
  - At displayx == H_TOTAL-1, displayx wraps to 0 and displayy increments.
  - At displayy == V_TOTAL-1 on that same line wrap, displayy wraps to 0.
- With en=0, all registers, including every pipeline stage, hold.
- blank = (x >= H_ACTIVE) | (y >= V_ACTIVE).
- hsync is active (== HSYNC_POL) iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
- vsync is active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for the whole line, independent of x.
- Delay pipeline: DELAY register stages, each advancing only on en=1. Output *_d equals stage-0 value as it was DELAY enabled cycles earlier. DELAY=0 connects *_d directly to stage 0.
- Coordinate arithmetic: unsigned, compared at X_W/Y_W width. No intermediate overflow occurs given the elaboration checks.
- Reset asserted mid-frame returns everything to the reset state immediately. After release, counting restarts at (0,0) on the first enabled edge: the first edge moves to (1,0).

Optional Feature:
- Macro XVGA_FRAME_COUNT_EN.
- Defined: frame_count increments (wrapping modulo 2**FRAME_W) on the enabled edge where displayy and displayx both wrap to 0. It is aligned with stage-0 frame_start.
- Undefined: the frame_count port exists but is tied to 0, and no counter logic is generated.

Test Plan:
- Reset with defaults, en=1 -> after release, displayx steps 0,1,2...; blank=0, hsync=vsync=1 until x reaches 1024; blank=1 at x=1024.
- Run one line -> hsync=0 exactly for x=1048..1183 (136 cycles); x=1343 then 0 with displayy 0->1; line_start high on the x=0 cycle only.
- Run full frame -> vsync=0 for lines 771..776; after (1343,805) the next state is (0,0) with frame_start=1; period is 1344*806 = 1083264 cycles; with XVGA_FRAME_COUNT_EN, frame_count 0->1.
- DELAY=3 -> displayx_d/displayy_d/hsync_d/vsync_d/blank_d match stage 0 exactly three enabled cycles later. DELAY=0 -> identical to stage 0 on the same cycle.
- Toggle en low for 5 cycles at x=500 -> all outputs, including *_d, hold; resume at x=501 with pipeline alignment preserved.
- Small raster (H 8/1/2/1, V 4/1/1/1, HSYNC_POL=1) with reset_n pulsed low at (5,2) -> immediate reset values; sync active-high at x=9..10; wrap at x=11, y=6.
